// File: rtl/beverage_payout_ctrl.sv
// Output-side actuator sequencer for the beverage vending FSM: buffers vend/change
// pulses in saturating pending counters and times the dispenser, hopper and cash box.
module beverage_payout_ctrl #(
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned PEND_W      = 3,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispense,
  input  logic              change_out,
  input  logic              collect,
  input  logic              drink_ack,
  output logic              drink_req,
  output logic              hopper_fire,
  output logic              cashbox_gate,
  output logic              busy,
  output logic [PEND_W-1:0] pend_drink,
  output logic [PEND_W-1:0] pend_change,
  output logic              overflow,
  output logic              fault
);

  localparam int unsigned TMAX_A = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TMAX   = (ACK_TIMEOUT > TMAX_A) ? ACK_TIMEOUT : TMAX_A;
  localparam int unsigned TMR_W  = $clog2(TMAX + 1);
  localparam int unsigned CB_W   = $clog2(PULSE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRINK_REQ,
    S_DRINK_REL,
    S_HOP_ON,
    S_HOP_GAP,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PEND_W-1:0]  pend_drink_q, pend_drink_d;
  logic [PEND_W-1:0]  pend_change_q, pend_change_d;
  logic               overflow_q, overflow_d;
  logic [CB_W-1:0]    cb_cnt_q, cb_cnt_d;
  logic               take_drink, take_change;
  logic               drink_drop, change_drop;

  // Returns {dropped, next_count}; a simultaneous increment and decrement cancel.
  function automatic logic [PEND_W:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [PEND_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == '1) r[PEND_W] = 1'b1;
      else           r = {1'b0, cnt + PEND_W'(1)};
    end else if (dec && !inc) begin
      r = {1'b0, cnt - PEND_W'(1)};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    take_drink  = 1'b0;
    take_change = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_drink_q != '0) begin
          state_d    = S_DRINK_REQ;
          timer_d    = '0;
          take_drink = 1'b1;
        end else if (pend_change_q != '0) begin
          state_d     = S_HOP_ON;
          timer_d     = '0;
          take_change = 1'b1;
        end
      end
      S_DRINK_REQ: begin
        if (drink_ack)                                  state_d = S_DRINK_REL;
        else if (timer_q == TMR_W'(ACK_TIMEOUT - 1))    state_d = S_FAULT;
        else                                            timer_d = timer_q + TMR_W'(1);
      end
      S_DRINK_REL: begin
        if (!drink_ack) state_d = S_IDLE;
      end
      S_HOP_ON: begin
        if (timer_q == TMR_W'(PULSE_CYC - 1)) begin
          state_d = S_HOP_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_HOP_GAP: begin
        // Back-to-back coins skip IDLE unless a drink is waiting, which must win.
        if (timer_q == TMR_W'(GAP_CYC - 1)) begin
          timer_d = '0;
          if (pend_change_q != '0 && pend_drink_q == '0) begin
            state_d     = S_HOP_ON;
            take_change = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drink_req   = (state_q == S_DRINK_REQ);
    hopper_fire = (state_q == S_HOP_ON);
    fault       = (state_q == S_FAULT);
    busy        = (state_q != S_IDLE) || (pend_drink_q != '0) || (pend_change_q != '0);
  end

  always_comb begin
    {drink_drop, pend_drink_d}   = pend_next(pend_drink_q, dispense, take_drink);
    {change_drop, pend_change_d} = pend_next(pend_change_q, change_out, take_change);
    overflow_d = overflow_q | drink_drop | change_drop;
    if (collect)               cb_cnt_d = CB_W'(PULSE_CYC);
    else if (cb_cnt_q != '0)   cb_cnt_d = cb_cnt_q - CB_W'(1);
    else                       cb_cnt_d = cb_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_drink_q  <= '0;
      pend_change_q <= '0;
      overflow_q    <= 1'b0;
      cb_cnt_q      <= '0;
    end else begin
      pend_drink_q  <= pend_drink_d;
      pend_change_q <= pend_change_d;
      overflow_q    <= overflow_d;
      cb_cnt_q      <= cb_cnt_d;
    end
  end

  assign pend_drink   = pend_drink_q;
  assign pend_change  = pend_change_q;
  assign overflow     = overflow_q;
  assign cashbox_gate = (cb_cnt_q != '0);

endmodule

// File: tb/tb_beverage_payout_ctrl.sv
// Scoreboard bench for beverage_payout_ctrl: stimulus queues timestamped actuator
// events; a negedge monitor detects edges on the outputs and checks them in order.
module tb_beverage_payout_ctrl;

  localparam int EV_REQ_RISE = 0;
  localparam int EV_REQ_FALL = 1;
  localparam int EV_HOP      = 2;
  localparam int EV_GATE     = 3;

  typedef struct {
    int    kind;
    int    cyc;
    int    width;
    string name;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, dispense, change_out, collect, drink_ack;
  logic       drink_req, hopper_fire, cashbox_gate, busy, overflow, fault;
  logic [2:0] pend_drink, pend_change;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  ev_t sb[$];

  beverage_payout_ctrl #(
    .PULSE_CYC  (4),
    .GAP_CYC    (2),
    .PEND_W     (3),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dispense    (dispense),
    .change_out  (change_out),
    .collect     (collect),
    .drink_ack   (drink_ack),
    .drink_req   (drink_req),
    .hopper_fire (hopper_fire),
    .cashbox_gate(cashbox_gate),
    .busy        (busy),
    .pend_drink  (pend_drink),
    .pend_change (pend_change),
    .overflow    (overflow),
    .fault       (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run incomplete at cyc %0d, required completion", cyc);
    $fatal(1);
  end

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic exp_ev(input int kind, input int c, input int w, input string name);
    ev_t e;
    e.kind = kind; e.cyc = c; e.width = w; e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic got(input int kind, input int c, input int w);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d width=%0d, required none", kind, c, w);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != c || e.width != w) begin
        fails++;
        $display("FAIL %s: got kind=%0d cyc=%0d width=%0d, required kind=%0d cyc=%0d width=%0d",
                 e.name, kind, c, w, e.kind, e.cyc, e.width);
      end
    end
  endtask

  // Monitor: stamps each output edge with the clock edge number that caused it.
  initial begin
    logic p_req, p_hop, p_gate;
    int   hop_rise, gate_rise;
    p_req = 1'b0; p_hop = 1'b0; p_gate = 1'b0;
    hop_rise = 0; gate_rise = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (drink_req && !p_req) got(EV_REQ_RISE, cyc, 0);
        if (!drink_req && p_req) got(EV_REQ_FALL, cyc, 0);
        if (hopper_fire && !p_hop) hop_rise = cyc;
        if (!hopper_fire && p_hop) got(EV_HOP, hop_rise, cyc - hop_rise);
        if (cashbox_gate && !p_gate) gate_rise = cyc;
        if (!cashbox_gate && p_gate) got(EV_GATE, gate_rise, cyc - gate_rise);
      end
      p_req = drink_req; p_hop = hopper_fire; p_gate = cashbox_gate;
    end
  end

  initial begin
    int c;
    rst = 1'b1; dispense = 1'b0; change_out = 1'b0; collect = 1'b0; drink_ack = 1'b0;
    at(2);
    rst = 1'b0;
    chk("reset_drink_req", int'(drink_req), 0);
    chk("reset_hopper", int'(hopper_fire), 0);
    chk("reset_gate", int'(cashbox_gate), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pend_drink", int'(pend_drink), 0);
    chk("reset_pend_change", int'(pend_change), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_fault", int'(fault), 0);
    mon_en = 1'b1;
    at(4);

    // Single vend, ack 3 cycles after request rises
    c = cyc;
    exp_ev(EV_REQ_RISE, c + 2, 0, "vend_req_rise");
    exp_ev(EV_REQ_FALL, c + 5, 0, "vend_req_fall");
    dispense = 1'b1;
    at(c + 1); dispense = 1'b0;
    chk("vend_pend_drink", int'(pend_drink), 1);
    at(c + 4); drink_ack = 1'b1;
    at(c + 6);
    chk("vend_busy_rel", int'(busy), 1);
    drink_ack = 1'b0;
    at(c + 7);
    chk("vend_busy_idle", int'(busy), 0);
    at(c + 10);

    // Three consecutive change pulses
    c = cyc;
    exp_ev(EV_HOP, c + 2, 4, "chg_hop1");
    exp_ev(EV_HOP, c + 8, 4, "chg_hop2");
    exp_ev(EV_HOP, c + 14, 4, "chg_hop3");
    change_out = 1'b1;
    at(c + 1);
    chk("chg_pend_1", int'(pend_change), 1);
    at(c + 3); change_out = 1'b0;
    chk("chg_pend_peak", int'(pend_change), 2);
    at(c + 21);
    chk("chg_pend_final", int'(pend_change), 0);
    chk("chg_overflow", int'(overflow), 0);
    chk("chg_busy_final", int'(busy), 0);

    // Simultaneous dispense and change: drink first
    c = cyc;
    exp_ev(EV_REQ_RISE, c + 2, 0, "both_req_rise");
    exp_ev(EV_REQ_FALL, c + 4, 0, "both_req_fall");
    exp_ev(EV_HOP, c + 6, 4, "both_hop");
    dispense = 1'b1; change_out = 1'b1;
    at(c + 1); dispense = 1'b0; change_out = 1'b0;
    chk("both_pend_drink", int'(pend_drink), 1);
    chk("both_pend_change", int'(pend_change), 1);
    at(c + 3); drink_ack = 1'b1;
    at(c + 4); drink_ack = 1'b0;
    at(c + 5);
    chk("both_change_waiting", int'(pend_change), 1);
    at(c + 20);

    // Overflow and ack timeout, then reset recovery
    c = cyc;
    exp_ev(EV_REQ_RISE, c + 2, 0, "ovf_req_rise");
    exp_ev(EV_REQ_FALL, c + 18, 0, "ovf_req_timeout");
    dispense = 1'b1;
    at(c + 9); dispense = 1'b0;
    chk("ovf_pend_sat", int'(pend_drink), 7);
    chk("ovf_flag", int'(overflow), 1);
    at(c + 17);
    chk("ovf_fault_early", int'(fault), 0);
    chk("ovf_req_held", int'(drink_req), 1);
    at(c + 18);
    chk("ovf_fault", int'(fault), 1);
    chk("ovf_req_drop", int'(drink_req), 0);
    at(c + 20); change_out = 1'b1;
    at(c + 21); change_out = 1'b0;
    chk("fault_change_counted", int'(pend_change), 1);
    at(c + 22);
    chk("fault_no_hopper", int'(hopper_fire), 0);
    chk("fault_change_held", int'(pend_change), 1);
    rst = 1'b1;
    at(c + 23); rst = 1'b0;
    chk("rst_fault", int'(fault), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pend_drink", int'(pend_drink), 0);
    chk("rst_pend_change", int'(pend_change), 0);
    chk("rst_busy", int'(busy), 0);
    at(c + 26);

    // Cash box retrigger, then a single gate pulse
    c = cyc;
    exp_ev(EV_GATE, c + 1, 6, "gate_retrig");
    exp_ev(EV_GATE, c + 11, 4, "gate_single");
    collect = 1'b1;
    at(c + 1); collect = 1'b0;
    at(c + 2); collect = 1'b1;
    at(c + 3); collect = 1'b0;
    at(c + 10); collect = 1'b1;
    at(c + 11); collect = 1'b0;
    at(c + 20);

    // Reset during HOP_ON with two coins still pending
    c = cyc;
    exp_ev(EV_HOP, c + 2, 2, "rst_hop_abort");
    change_out = 1'b1;
    at(c + 3); change_out = 1'b0;
    chk("rsthop_pend_before", int'(pend_change), 2);
    chk("rsthop_firing", int'(hopper_fire), 1);
    rst = 1'b1;
    at(c + 4); rst = 1'b0;
    chk("rsthop_fire_off", int'(hopper_fire), 0);
    chk("rsthop_pend_change", int'(pend_change), 0);
    chk("rsthop_pend_drink", int'(pend_drink), 0);
    at(c + 30);
    chk("rsthop_quiet_busy", int'(busy), 0);

    chk("leftover_expected_events", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
